// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data ports: one transaction per grant, bounded by TIMEOUT.
// MEM_ARB_RR_EN: alternate grants on contention instead of fixed data-first priority.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 31
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_done_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          d_rd_i,
  input  logic          d_wr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_done_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_stall_o,
  output logic          mem_en_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_en_q, mem_wr_q, if_done_q, d_done_q, err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic          last_d_q;
`endif

  logic if_cand, d_cand, d_bad, pick_d;

  // A port whose done strobe is up this cycle is not re-sampled until the next cycle.
  always_comb begin
    if_cand = if_req_i & ~if_done_q;
    d_cand  = (d_rd_i | d_wr_i) & ~d_done_q;
    d_bad   = (d_rd_i & d_wr_i) | d_addr_i[0];
`ifdef MEM_ARB_RR_EN
    pick_d  = d_cand & (~if_cand | ~last_d_q);
`else
    pick_d  = d_cand;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      mem_en_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (pick_d && d_bad) begin
            err_q    <= 1'b1;
            d_done_q <= 1'b1;
          end else if (pick_d) begin
            state_q     <= BUSY_D;
            cnt_q       <= '0;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= d_wr_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b1;
`endif
          end else if (if_cand) begin
            state_q     <= BUSY_I;
            cnt_q       <= '0;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem_ready_i) begin
            state_q <= DONE;
            if (state_q == BUSY_I) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end else begin
              d_done_q <= 1'b1;
              if (!mem_wr_q) d_rdata_q <= mem_rdata_i;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            if (state_q == BUSY_I) if_done_q <= 1'b1;
            else                   d_done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done_o   = if_done_q;
  assign d_done_o    = d_done_q;
  assign err_o       = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_done_q & ~rst_i;
  assign d_stall_o   = (d_rd_i | d_wr_i) & ~d_done_q & ~rst_i;
endmodule
